// File: rtl/alu_arbiter_pkg.sv
// Shared constants and state encoding for the ALU arbiter.
// Opcode map, flag bit positions and FSM states.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBB = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;
  localparam logic [3:0] OP_DEC = 4'hC;

  localparam int CARRY    = 0;
  localparam int SIGN     = 1;
  localparam int OVERFLOW = 2;
  localparam int ZERO     = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational one-hot round-robin pick: first set req
// at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between several requesters, round-robin.
// Latches the winner's op, waits for the ALU, returns the result.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int                REQUESTERS  = 4,
  parameter int                WIDTH       = 32,
  parameter int                OPCODE      = 4,
  parameter int                REGS_CODING = 3,
  parameter int                FLAGS       = 4,
  parameter logic [OPCODE-1:0] DIV_OPCODE  = OPCODE'(OP_DIV),
  parameter int                DIV_LATENCY = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [REQUESTERS-1:0]             req,
  input  logic [REQUESTERS*OPCODE-1:0]      req_opcode,
  input  logic [REQUESTERS*WIDTH-1:0]       req_op1,
  input  logic [REQUESTERS*WIDTH-1:0]       req_op2,
  input  logic [REQUESTERS-1:0]             req_cin,
  input  logic [REQUESTERS*REGS_CODING-1:0] req_dest,
  output logic [REQUESTERS-1:0]             grant,
  output logic                              alu_en,
  output logic [OPCODE-1:0]                 alu_opcode,
  output logic [WIDTH-1:0]                  alu_op1,
  output logic [WIDTH-1:0]                  alu_op2,
  output logic                              alu_cin,
  output logic [REGS_CODING-1:0]            alu_dest,
  input  logic [WIDTH-1:0]                  alu_result,
  input  logic [FLAGS-1:0]                  alu_flags,
  input  logic [REGS_CODING-1:0]            alu_dest_out,
  output logic [REQUESTERS-1:0]             rsp_valid,
  output logic [WIDTH-1:0]                  rsp_result,
  output logic [FLAGS-1:0]                  rsp_flags,
  output logic [REGS_CODING-1:0]            rsp_dest,
  output logic                              busy
);

  localparam int PW = $clog2(REQUESTERS);
  localparam int CW = $clog2(DIV_LATENCY + 1);

  state_t                  state;
  state_t                  state_n;
  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           owner;
  logic [PW-1:0]           win;
  logic [CW-1:0]           cnt;
  logic [REQUESTERS-1:0]   arb_grant;
  logic                    arb_any;
  logic                    take;
  logic [OPCODE-1:0]       win_opc;

  rr_arbiter #(
    .N(REQUESTERS)
  ) u_rr (
    .req  (req),
    .ptr  (rr_ptr),
    .grant(arb_grant),
    .idx  (win),
    .any  (arb_any)
  );

  assign take    = (state == S_IDLE) && arb_any && !reset;
  assign grant   = take ? arb_grant : '0;
  assign win_opc = req_opcode[win*OPCODE +: OPCODE];
  assign alu_en  = (state == S_EXEC);
  assign busy    = (state != S_IDLE);

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (take) state_n = S_EXEC;
      S_EXEC:  if (cnt == '0) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_cin    <= 1'b0;
      alu_dest   <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_dest   <= '0;
    end else begin
      if (take) begin
        alu_opcode <= win_opc;
        alu_op1    <= req_op1[win*WIDTH +: WIDTH];
        alu_op2    <= req_op2[win*WIDTH +: WIDTH];
        alu_cin    <= req_cin[win];
        alu_dest   <= req_dest[win*REGS_CODING +: REGS_CODING];
        owner      <= win;
        rr_ptr     <= (win == PW'(REQUESTERS - 1)) ? '0 : win + 1'b1;
        cnt        <= (win_opc == DIV_OPCODE) ? CW'(DIV_LATENCY - 1) : '0;
      end
      // Division results are only trusted after the full settle count.
      if (state == S_EXEC) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_dest   <= alu_dest_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a latency-based reference model
// and a behavioural ALU stub that only settles division after the full count.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int OW = 4;
  localparam int RC = 3;
  localparam int FL = 4;
  localparam int DL = 4;

  typedef struct packed {
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [2:0]  dest;
  } op_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*OW-1:0] req_opcode;
  logic [N*W-1:0]  req_op1;
  logic [N*W-1:0]  req_op2;
  logic [N-1:0]    req_cin;
  logic [N*RC-1:0] req_dest;
  logic [N-1:0]    grant;
  logic            alu_en;
  logic [OW-1:0]   alu_opcode;
  logic [W-1:0]    alu_op1;
  logic [W-1:0]    alu_op2;
  logic            alu_cin;
  logic [RC-1:0]   alu_dest;
  logic [W-1:0]    alu_result;
  logic [FL-1:0]   alu_flags;
  logic [RC-1:0]   alu_dest_out;
  logic [N-1:0]    rsp_valid;
  logic [W-1:0]    rsp_result;
  logic [FL-1:0]   rsp_flags;
  logic [RC-1:0]   rsp_dest;
  logic            busy;

  alu_arbiter #(
    .REQUESTERS (N),
    .WIDTH      (W),
    .OPCODE     (OW),
    .REGS_CODING(RC),
    .FLAGS      (FL),
    .DIV_OPCODE (OP_DIV),
    .DIV_LATENCY(DL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_opcode  (req_opcode),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_cin     (req_cin),
    .req_dest    (req_dest),
    .grant       (grant),
    .alu_en      (alu_en),
    .alu_opcode  (alu_opcode),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_cin     (alu_cin),
    .alu_dest    (alu_dest),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .alu_dest_out(alu_dest_out),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_dest    (rsp_dest),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // {flags, result}; flags = {ZERO, OVERFLOW, SIGN, CARRY}
  function automatic logic [35:0] alu_fn(op_t o);
    logic [32:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (o.opc)
      OP_ADD, OP_ADC: begin
        r = {1'b0, o.a} + {1'b0, o.b};
        if (o.opc == OP_ADC) r = r + 33'(o.cin);
        v = (o.a[31] == o.b[31]) && (r[31] != o.a[31]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        r = {1'b0, o.a} - {1'b0, o.b};
        if (o.opc == OP_SBB) r = r - 33'(o.cin);
        v = (o.a[31] != o.b[31]) && (r[31] != o.a[31]);
      end
      OP_MUL: r = {1'b0, o.a * o.b};
      OP_DIV: r = {1'b0, (o.b == 0) ? 32'hFFFF_FFFF : o.a / o.b};
      OP_AND: r = {1'b0, o.a & o.b};
      OP_OR:  r = {1'b0, o.a | o.b};
      OP_XOR: r = {1'b0, o.a ^ o.b};
      OP_NOT: r = {1'b0, ~o.a};
      OP_INC: r = {1'b0, o.a} + 33'd1;
      OP_DEC: r = {1'b0, o.a} - 33'd1;
      default: r = {1'b0, o.a};
    endcase
    return {~|r[31:0], v, r[31], r[32], r[31:0]};
  endfunction

  // ALU stub: division output is garbage until it has had DL cycles
  op_t         alu_in;
  logic [35:0] alu_out;
  int          en_cnt = 0;

  assign alu_in = {alu_opcode, alu_op1, alu_op2, alu_cin, alu_dest};
  assign alu_out = alu_fn(alu_in);
  assign alu_result = (alu_opcode == OP_DIV && en_cnt < DL - 1)
                    ? 32'hDEAD_BEEF : alu_out[31:0];
  assign alu_flags = alu_out[35:32];
  assign alu_dest_out = alu_dest;

  always @(posedge clk) en_cnt <= alu_en ? en_cnt + 1 : 0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus state and reference model
  op_t          r_op [N];
  logic [N-1:0] r_req;
  int           m_k;
  int           m_lat;
  int           m_own;
  int           m_ptr;
  op_t          m_op;
  logic [W-1:0]  last_res;
  logic [FL-1:0] last_flg;
  logic [RC-1:0] last_dst;
  logic [N-1:0]  last_grant;

  function automatic int pick();
    if (m_k != 0 || reset || r_req == '0) return -1;
    for (int k = 0; k < N; k++)
      if (r_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]              = r_req[i];
      req_opcode[i*OW +: OW] = r_op[i].opc;
      req_op1[i*W +: W]   = r_op[i].a;
      req_op2[i*W +: W]   = r_op[i].b;
      req_cin[i]          = r_op[i].cin;
      req_dest[i*RC +: RC] = r_op[i].dest;
    end
  endtask

  task automatic step(output int g, output int rv);
    logic [N-1:0] eg;
    logic [35:0]  e;
    bit           infl;
    @(negedge clk);
    drive();
    #1;
    g = pick();
    eg = (g >= 0) ? (N'(1) << g) : '0;
    last_grant = grant;
    chk("grant", grant, eg);
    infl = (m_k != 0);
    chk("busy", busy, infl);
    chk("alu_en", alu_en, infl && m_k < m_lat);
    rv = (infl && m_k == m_lat) ? m_own : -1;
    chk("rsp_valid", rsp_valid, (rv >= 0) ? (N'(1) << rv) : '0);
    if (rv >= 0) begin
      e = alu_fn(m_op);
      chk("rsp_result", rsp_result, e[31:0]);
      chk("rsp_flags", rsp_flags, e[35:32]);
      chk("rsp_dest", rsp_dest, m_op.dest);
      last_res = rsp_result;
      last_flg = rsp_flags;
      last_dst = rsp_dest;
    end
    if (infl && m_k < m_lat)
      chk("alu_inputs", alu_in, m_op);
    @(posedge clk);
    if (reset) begin
      m_k = 0;
      m_ptr = 0;
    end else if (g >= 0) begin
      m_op  = r_op[g];
      m_own = g;
      m_lat = (r_op[g].opc == OP_DIV) ? DL + 1 : 2;
      m_k   = 1;
      m_ptr = (g + 1) % N;
    end else if (m_k != 0) begin
      m_k++;
      if (m_k > m_lat) m_k = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant, '0);
    chk({tag, "_alu_en"}, alu_en, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_alu_in"}, alu_in, '0);
    chk({tag, "_rsp"}, {rsp_result, rsp_flags, rsp_dest}, '0);
  endtask

  task automatic do_reset();
    int g, rv;
    #2 reset = 1'b1;
    m_k = 0;
    m_ptr = 0;
    step(g, rv);
    #3 reset = 1'b0;
  endtask

  function automatic op_t mk(logic [3:0] opc, logic [31:0] a,
                             logic [31:0] b, logic [2:0] d);
    op_t o;
    o.opc = opc;
    o.a = a;
    o.b = b;
    o.cin = 1'b0;
    o.dest = d;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.opc  = ($urandom_range(3) == 0) ? OP_DIV : 4'($urandom_range(15));
    o.a    = $urandom;
    o.b    = ($urandom_range(3) == 0) ? 32'($urandom_range(20)) : $urandom;
    o.cin  = 1'($urandom_range(1));
    o.dest = 3'($urandom_range(7));
    return o;
  endfunction

  task automatic run_one(input int w, input op_t o, input int want,
                         input string tag);
    int g, rv, gc, lat;
    bit got_g, got_r;
    r_op[w] = o;
    r_req[w] = 1'b1;
    got_g = 0;
    got_r = 0;
    gc = -1;
    lat = -1;
    for (int c = 0; c < 30 && !got_r; c++) begin
      step(g, rv);
      if (g == w && !got_g) begin
        got_g = 1;
        gc = c;
        r_req[w] = 1'b0;
      end
      if (rv == w && got_g) begin
        got_r = 1;
        lat = c - gc;
      end
    end
    chk({tag, "_done"}, got_r, 1'b1);
    chk({tag, "_grant_cycle"}, gc, 0);
    chk({tag, "_latency"}, lat, want);
  endtask

  initial begin
    int g, rv, n_g1, n_r0, n_gr;
    int gw [8];
    int gt [8];

    reset = 1'b1;
    r_req = '0;
    for (int i = 0; i < N; i++) r_op[i] = '0;
    m_k = 0;
    m_ptr = 0;
    m_lat = 2;
    m_own = 0;
    m_op = '0;
    drive();
    #1;
    chk_zero("reset");
    step(g, rv);
    step(g, rv);
    #3 reset = 1'b0;

    // single add
    run_one(0, mk(OP_ADD, 5, 7, 3'd1), 2, "add");
    chk("add_result", last_res, 32'd12);
    chk("add_zero", last_flg[ZERO], 1'b0);

    // round-robin fairness from rr_ptr=0
    do_reset();
    for (int i = 0; i < N; i++) begin
      r_op[i] = mk(OP_ADD, 32'(i), 32'(10 * i), 3'(i));
      r_req[i] = 1'b1;
    end
    n_gr = 0;
    for (int c = 0; c < 24; c++) begin
      step(g, rv);
      if (g >= 0 && n_gr < 8) begin
        gw[n_gr] = g;
        gt[n_gr] = c;
        n_gr++;
        r_op[g].a = $urandom;
      end
    end
    r_req = '0;
    chk("rr_count", n_gr, 8);
    for (int j = 0; j < 8; j++) begin
      chk("rr_order", gw[j], j % N);
      chk("rr_spacing", gt[j], 3 * j);
    end

    // division latency
    step(g, rv);
    run_one(2, mk(OP_DIV, 100, 7, 3'd2), DL + 1, "div");
    chk("div_result", last_res, 32'd14);

    // zero flag and destination pass-through
    run_one(3, mk(OP_SUB, 9, 9, 3'b101), 2, "zero");
    chk("zero_result", last_res, 32'd0);
    chk("zero_flag", last_flg[ZERO], 1'b1);
    chk("zero_dest", last_dst, 3'd5);

    // async reset two cycles into a division
    r_op[2] = mk(OP_DIV, 1000, 3, 3'd6);
    r_req[2] = 1'b1;
    n_gr = 0;
    for (int c = 0; c < 10 && n_gr == 0; c++) begin
      step(g, rv);
      if (g == 2) n_gr = 1;
    end
    chk("rst_div_granted", n_gr, 1);
    r_req[2] = 1'b0;
    step(g, rv);
    step(g, rv);
    #2 reset = 1'b1;
    #1;
    chk_zero("midreset");
    m_k = 0;
    m_ptr = 0;
    r_req = 4'b1100;
    r_op[3] = mk(OP_OR, 32'h30, 32'h3, 3'd3);
    step(g, rv);
    step(g, rv);
    #3 reset = 1'b0;
    step(g, rv);
    chk("rst_first_grant", last_grant, 4'b0100);
    r_req = '0;
    for (int c = 0; c < 8; c++) step(g, rv);

    // request raised and withdrawn while busy
    n_g1 = 0;
    n_r0 = 0;
    r_op[0] = mk(OP_XOR, 32'hF0, 32'h0F, 3'd4);
    r_op[1] = mk(OP_AND, 32'hFF, 32'h0F, 3'd7);
    r_req[0] = 1'b1;
    step(g, rv);
    r_req[0] = 1'b0;
    r_req[1] = 1'b1;
    step(g, rv);
    if (g == 1 || last_grant[1]) n_g1++;
    r_req[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(g, rv);
      if (g == 1 || last_grant[1]) n_g1++;
      if (rv == 0) n_r0++;
    end
    chk("wd_no_grant1", n_g1, 0);
    chk("wd_rsp0", n_r0, 1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!r_req[i] && $urandom_range(2) == 0) begin
          r_op[i] = rand_op();
          r_req[i] = 1'b1;
        end
      step(g, rv);
      if (g >= 0) begin
        if ($urandom_range(1) == 1) r_op[g] = rand_op();
        else r_req[g] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
